// File: rtl/conv3x3_stream.sv
// 3x3 streaming convolution: two line buffers build a sliding window over a
// raster pixel stream; Sobel X / Sobel Y / |X|+|Y| / loadable user kernel.
// Three stages (window, sums, abs+saturate) share one advance enable.

// One window tap: pixel times the fixed Sobel weights and the user coefficient.
module conv3x3_tap #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 4,
  parameter int AW     = 21,
  parameter int KX     = 0,
  parameter int KY     = 0
) (
  input  logic        [DATA_W-1:0] pix,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [AW-1:0]     px,
  output logic signed [AW-1:0]     py,
  output logic signed [AW-1:0]     pu
);
  logic signed [AW-1:0] pe, ce;

  // Sobel weights are only 0, +-1, +-2, so they reduce to negate/shift.
  function automatic logic signed [AW-1:0] kmul(input int k, input logic signed [AW-1:0] p);
    case (k)
      0:       kmul = '0;
      1:       kmul = p;
      -1:      kmul = -p;
      2:       kmul = p <<< 1;
      default: kmul = -(p <<< 1);
    endcase
  endfunction

  assign pe = $signed({{(AW-DATA_W){1'b0}}, pix});
  assign ce = $signed({{(AW-COEF_W){coef[COEF_W-1]}}, coef});
  assign pu = pe * ce;
  assign px = kmul(KX, pe);
  assign py = kmul(KY, pe);
endmodule

module conv3x3_stream #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 1280,
  parameter int IMG_H  = 960,
  parameter int COEF_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        mode,
  input  logic              coef_we,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);
  localparam int AW     = DATA_W + COEF_W + 5;
  localparam int XW     = $clog2(IMG_W);
  localparam int YW     = $clog2(IMG_H);
  localparam int STAGES = 2;

  typedef struct packed {
    logic signed [AW-1:0] sx;
    logic signed [AW-1:0] sy;
    logic signed [AW-1:0] su;
    logic [1:0]           mode;
  } sums_t;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0]    mode_q;
  logic [8:0][COEF_W-1:0] coef;
  logic [STAGES:0] vld_pipe, last_pipe;
  logic en, acc, at_org, x_end, y_end;

  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [2:0][2:0][DATA_W-1:0] win;

  logic signed [AW-1:0] px [9];
  logic signed [AW-1:0] py [9];
  logic signed [AW-1:0] pu [9];
  sums_t sums, s1;
  logic [AW-1:0] ax, ay, au;
  logic [AW:0]   mag;
  logic [DATA_W-1:0] sat;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign acc       = in_valid && en;
  assign at_org    = (x == '0) && (y == '0);
  assign x_end     = (x == XW'(IMG_W-1));
  assign y_end     = (y == YW'(IMG_H-1));
  assign out_valid = vld_pipe[STAGES];
  assign out_last  = last_pipe[STAGES];

  // Line buffers and window shift on every accepted pixel (contents never reset).
  always_ff @(posedge clk) begin
    if (acc) begin
      lb0[x] <= lb1[x];
      lb1[x] <= in_data;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb0[x];
      win[1][2] <= lb1[x];
      win[2][2] <= in_data;
    end
  end

  for (genvar i = 0; i < 9; i++) begin : g_tap
    localparam int R   = i / 3;
    localparam int C   = i % 3;
    localparam int KXV = (C == 0 ? 1 : C == 2 ? -1 : 0) * (R == 1 ? 2 : 1);
    localparam int KYV = (R == 0 ? -1 : R == 2 ? 1 : 0) * (C == 1 ? 2 : 1);
    conv3x3_tap #(.DATA_W(DATA_W), .COEF_W(COEF_W), .AW(AW), .KX(KXV), .KY(KYV)) u_tap (
      .pix (win[R][C]),
      .coef(coef[i]),
      .px  (px[i]),
      .py  (py[i]),
      .pu  (pu[i])
    );
  end

  // Adder trees for all three kernels; the frame mode picks one later.
  always_comb begin
    sums      = '0;
    sums.mode = mode_q;
    for (int i = 0; i < 9; i++) begin
      sums.sx = sums.sx + px[i];
      sums.sy = sums.sy + py[i];
      sums.su = sums.su + pu[i];
    end
  end

  // Magnitude select and saturation for the output stage.
  always_comb begin
    ax = s1.sx[AW-1] ? AW'(-s1.sx) : AW'(s1.sx);
    ay = s1.sy[AW-1] ? AW'(-s1.sy) : AW'(s1.sy);
    au = s1.su[AW-1] ? AW'(-s1.su) : AW'(s1.su);
    case (s1.mode)
      2'd0:    mag = {1'b0, au};
      2'd1:    mag = {1'b0, ax};
      2'd2:    mag = {1'b0, ay};
      default: mag = {1'b0, ax} + {1'b0, ay};
    endcase
    sat = (|mag[AW:DATA_W]) ? '1 : mag[DATA_W-1:0];
  end

  // Position counters, frame mode, pipeline stages, busy and coefficients.
  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      mode_q    <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      s1        <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      coef      <= '0;
    end else begin
      if (acc) begin
        if (at_org) mode_q <= mode;
        if (x_end) begin
          x <= '0;
          y <= y_end ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
      if (en) begin
        vld_pipe  <= {vld_pipe[STAGES-1:0], acc && (x >= XW'(2)) && (y >= YW'(2))};
        last_pipe <= {last_pipe[STAGES-1:0], acc && x_end && y_end};
        s1        <= sums;
        out_data  <= sat;
      end
      // A new frame started after the last pixel keeps busy high (x/y leave origin).
      if (acc && at_org)
        busy <= 1'b1;
      else if (out_valid && out_ready && out_last && at_org)
        busy <= 1'b0;
      if (coef_we && !busy && (coef_addr <= 4'd8))
        coef[coef_addr] <= coef_data;
    end
  end
endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream: table of frame runs checked against a direct
// 2-D convolution model, plus reset-state and mid-frame-reset sequences.
module tb_conv3x3_stream;
  localparam int DW    = 12;
  localparam int W     = 8;
  localparam int H     = 4;
  localparam int CW    = 4;
  localparam int MAXV  = (1 << DW) - 1;
  localparam int LIMIT = 3000;
  localparam int KX[9] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
  localparam int KY[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, coef_we, out_valid, out_ready, out_last, busy;
  logic [DW-1:0] in_data, out_data;
  logic [1:0] mode;
  logic [3:0] coef_addr;
  logic [CW-1:0] coef_data;

  conv3x3_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .COEF_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;        // frame mode, -1 = random
    int mode_after;  // mode driven after (0,0) is taken, -1 = random
    int pat;         // 0 ramp 10x, 1 step at x>=4, 2 x+8y, 3 random
    int rdy;         // out_ready percentage
    int gaps;        // random in_valid bubbles
    int cset;        // 0 keep, 1 centre -1, 2 random coefficients
    int mid_we;      // coefficient write attempted mid-frame
    int lat;         // check first-result latency
    int exp_all;     // every result must equal this, -1 = model only
  } vec_t;

  int img[H][W];
  int coef_sh[9];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  function automatic int pix(input int pat, input int x, input int y);
    case (pat)
      0: return 10 * x;
      1: return (x >= 4) ? MAXV : 0;
      2: return x + 8 * y;
      default: return int'($urandom_range(0, MAXV));
    endcase
  endfunction

  function automatic int kc(input int m, input int i);
    case (m)
      1: return KX[i];
      2: return KY[i];
      default: return coef_sh[i];
    endcase
  endfunction

  // Window whose newest pixel is (x,y): rows y-2..y, columns x-2..x.
  function automatic int conv(input int m, input int x, input int y);
    int s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += kc(m, r * 3 + c) * img[y - 2 + r][x - 2 + c];
    return s;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int ref_val(input int m, input int x, input int y);
    int v;
    if (m == 3) v = iabs(conv(1, x, y)) + iabs(conv(2, x, y));
    else        v = iabs(conv(m, x, y));
    return (v > MAXV) ? MAXV : v;
  endfunction

  // Only called while the block is idle, so the write must land (addr<9).
  task automatic load_coef(input int a, input int d);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 4'(a);
    coef_data = CW'(d);
    if (a < 9) coef_sh[a] = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    int m, ma, pi, got, cyc, acc22, first_ov, busy_done, stalled, held, held_last;
    int exp_d[$];
    int exp_l[$];
    m  = (v.mode < 0) ? int'($urandom_range(0, 3)) : v.mode;
    ma = (v.mode_after < 0) ? int'($urandom_range(0, 3)) : v.mode_after;
    if (v.cset == 1) begin
      for (int i = 0; i < 9; i++) load_coef(i, (i == 4) ? -1 : 0);
      load_coef(12, 5);
    end else if (v.cset == 2) begin
      for (int i = 0; i < 9; i++) load_coef(i, int'($urandom_range(0, 15)) - 8);
    end
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        img[yy][xx] = pix(v.pat, xx, yy);
    for (int yy = 2; yy < H; yy++)
      for (int xx = 2; xx < W; xx++) begin
        exp_d.push_back(ref_val(m, xx, yy));
        exp_l.push_back((xx == W - 1 && yy == H - 1) ? 1 : 0);
      end
    pi = 0; got = 0; cyc = 0; acc22 = -1; first_ov = -1;
    busy_done = 0; stalled = 0; held = 0; held_last = 0;
    while ((pi < W * H || got < exp_d.size()) && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      in_valid  = (pi < W * H) && (v.gaps == 0 || $urandom_range(0, 3) != 0);
      in_data   = (pi < W * H) ? DW'(img[pi / W][pi % W]) : '0;
      mode      = 2'((pi == 0) ? m : ma);
      out_ready = int'($urandom_range(0, 99)) < v.rdy;
      coef_we   = (v.mid_we != 0) && (pi == 20);
      coef_addr = 4'd4;
      coef_data = CW'(1);
      #1;
      if (stalled != 0) begin
        chk("stall_data", int'(out_data), held);
        chk("stall_last", int'(out_last), held_last);
      end
      if (out_valid && !out_ready) chk("stall_in_ready", int'(in_ready), 0);
      if (pi > 0 && busy_done == 0) begin
        chk("busy_high", int'(busy), 1);
        busy_done = 1;
      end
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (out_valid && out_ready) begin
        if (got < exp_d.size()) begin
          chk("data", int'(out_data), exp_d[got]);
          chk("last", int'(out_last), exp_l[got]);
          if (v.exp_all >= 0) chk("const", int'(out_data), v.exp_all);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        if (pi == 2 * W + 2) acc22 = cyc;
        pi++;
      end
      stalled   = (out_valid && !out_ready) ? 1 : 0;
      held      = int'(out_data);
      held_last = int'(out_last);
    end
    in_valid  = 1'b0;
    coef_we   = 1'b0;
    out_ready = 1'b1;
    chk("result_count", got, exp_d.size());
    // Accept edge of (2,2) lies between samples; two edges later the sample sees out_valid.
    if (v.lat != 0) chk("latency", first_ov - acc22, 3);
    @(negedge clk);
    #1;
    chk("idle_valid", int'(out_valid), 0);
    chk("busy_low", int'(busy), 0);
  endtask

  task automatic reset_mid();
    int pi = 0;
    int cyc = 0;
    while (pi < 13 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      in_valid  = 1'b1;
      in_data   = DW'(10 * (pi % W));
      mode      = 2'd1;
      out_ready = 1'b1;
      #1;
      if (in_valid && in_ready) pi++;
    end
    chk("pre_reset_accepts", pi, 13);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_data", int'(out_data), 0);
    chk("rst_mid_last", int'(out_last), 0);
    for (int i = 0; i < 9; i++) coef_sh[i] = 0;
  endtask

  vec_t vecs[8];
  vec_t zero_user, sobel_again;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    for (int i = 0; i < 9; i++) coef_sh[i] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    vecs[0] = '{1, 2, 0, 100, 0, 0, 0, 1, 80};   // Sobel X ramp, mode changes mid-frame
    vecs[1] = '{2, 2, 0, 100, 0, 0, 0, 0, 0};    // Sobel Y ramp
    vecs[2] = '{3, 3, 1, 100, 0, 0, 0, 0, -1};   // magnitude saturation step
    vecs[3] = '{1, 1, 0, 50, 0, 0, 0, 0, 80};    // Sobel X under backpressure
    vecs[4] = '{0, 0, 2, 70, 1, 1, 1, 0, -1};    // user centre kernel, ignored mid-frame write
    vecs[5] = '{-1, -1, 3, 60, 1, 2, 0, 0, -1};  // random frames
    vecs[6] = '{-1, -1, 3, 60, 1, 2, 1, 0, -1};
    vecs[7] = '{-1, -1, 3, 40, 1, 2, 0, 0, -1};
    for (int k = 0; k < 8; k++) run_frame(vecs[k]);

    reset_mid();
    zero_user   = '{0, 0, 3, 80, 1, 0, 0, 0, 0};  // coefficients cleared by reset
    sobel_again = '{1, 1, 0, 100, 0, 0, 0, 1, 80};
    run_frame(zero_user);
    run_frame(sobel_again);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
